bram_write_arbiter: RTL and testbench

- Round-robin arbiter that shares the write port (clka side) of the team's simple dual-port two-clock frame RAM among NUM_REQ producers.
- Each producer owns a fixed, equal, power-of-two region of the RAM. The arbiter keeps a per-region write pointer and issues registered wea/addra/dina to the RAM.
- Grants are held for bursts of up to MAX_BURST beats. The read side (clkb) is untouched by this block.

---
 rtl/bram_write_arbiter.sv | 151 +++++++++++++++
 tb/tb_bram_write_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_write_arbiter.sv
// Round-robin arbiter sharing the clka write port of the frame RAM among 2**REQ_W producers.
// Each producer owns one equal region; writes are issued one cycle after the handshake.
module bram_write_arbiter #(
  parameter int unsigned REQ_W     = 2,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned RAM_WIDTH = 16,
  parameter int unsigned MAX_BURST = 16,
  localparam int unsigned NUM_REQ  = 1 << REQ_W
) (
  input  logic                           clka,
  input  logic                           rstb,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*RAM_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [ADDR_W-1:0]              addra,
  output logic [RAM_WIDTH-1:0]           dina,
  output logic                           wea,
  output logic [NUM_REQ-1:0]             frame_done,
  output logic [NUM_REQ-1:0]             region_wrap,
  output logic                           busy,
  output logic [REQ_W-1:0]               grant_id
);

  localparam int unsigned PTR_W = ADDR_W - REQ_W;
  localparam int unsigned CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic {StIdle, StBurst} state_e;

  state_e                 state_q, state_d;
  logic [REQ_W-1:0]       grant_q, grant_d;
  logic [REQ_W-1:0]       last_grant_q, last_grant_d;
  logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
  logic [PTR_W-1:0]       ptr_q [NUM_REQ];
  logic [PTR_W-1:0]       ptr_d [NUM_REQ];
  logic                   wea_q, wea_d;
  logic [ADDR_W-1:0]      addra_q, addra_d;
  logic [RAM_WIDTH-1:0]   dina_q, dina_d;
  logic [NUM_REQ-1:0]     frame_done_q, frame_done_d;
  logic [NUM_REQ-1:0]     region_wrap_q, region_wrap_d;

  // Ready depends only on state and reset so the producer never sees a valid->ready loop.
  always_comb begin
    req_ready = '0;
    if (state_q == StBurst && !rstb) begin
      req_ready[grant_q] = 1'b1;
    end
  end

  always_comb begin
    logic             found;
    logic [REQ_W-1:0] cand;
    logic             finish;

    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    beat_cnt_d    = beat_cnt_q;
    ptr_d         = ptr_q;
    wea_d         = 1'b0;
    addra_d       = addra_q;
    dina_d        = dina_q;
    frame_done_d  = '0;
    region_wrap_d = '0;
    found         = 1'b0;
    cand          = '0;
    finish        = 1'b0;

    unique case (state_q)
      StIdle: begin
        // k == NUM_REQ truncates to zero, giving last_grant itself the lowest priority.
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
          cand = last_grant_q + REQ_W'(k);
          if (!found && req_valid[cand]) begin
            found   = 1'b1;
            grant_d = cand;
          end
        end
        if (found) begin
          beat_cnt_d = '0;
          state_d    = StBurst;
        end
      end
      StBurst: begin
        if (req_valid[grant_q]) begin
          wea_d      = 1'b1;
          addra_d    = {grant_q, ptr_q[grant_q]};
          dina_d     = req_data[grant_q*RAM_WIDTH +: RAM_WIDTH];
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (req_last[grant_q]) begin
            ptr_d[grant_q]        = '0;
            frame_done_d[grant_q] = 1'b1;
            finish                = 1'b1;
          end else if (&ptr_q[grant_q]) begin
            ptr_d[grant_q]         = '0;
            region_wrap_d[grant_q] = 1'b1;
          end else begin
            ptr_d[grant_q] = ptr_q[grant_q] + 1'b1;
          end
          if (beat_cnt_q == CNT_W'(MAX_BURST - 1)) begin
            finish = 1'b1;
          end
        end else begin
          finish = 1'b1;
        end
        if (finish) begin
          last_grant_d = grant_q;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clka) begin
    if (rstb) begin
      state_q       <= StIdle;
      grant_q       <= '0;
      last_grant_q  <= REQ_W'(NUM_REQ - 1);
      beat_cnt_q    <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        ptr_q[i] <= '0;
      end
      wea_q         <= 1'b0;
      addra_q       <= '0;
      dina_q        <= '0;
      frame_done_q  <= '0;
      region_wrap_q <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      beat_cnt_q    <= beat_cnt_d;
      ptr_q         <= ptr_d;
      wea_q         <= wea_d;
      addra_q       <= addra_d;
      dina_q        <= dina_d;
      frame_done_q  <= frame_done_d;
      region_wrap_q <= region_wrap_d;
    end
  end

  assign wea         = wea_q;
  assign addra       = addra_q;
  assign dina        = dina_q;
  assign frame_done  = frame_done_q;
  assign region_wrap = region_wrap_q;
  assign busy        = (state_q == StBurst);
  assign grant_id    = grant_q;

endmodule

// File: tb/tb_bram_write_arbiter.sv
// Bench for bram_write_arbiter: a per-cycle behavioural model checked against every output,
// plus directed scenarios with literal expectations on the observed writes and grant order.
module tb_bram_write_arbiter;

  localparam int NUM    = 4;
  localparam int REGION = 1024;
  localparam int MB     = 4;

  logic        clka = 1'b0;
  logic        rstb = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [63:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic [11:0] addra;
  logic [15:0] dina;
  logic        wea;
  logic [3:0]  frame_done;
  logic [3:0]  region_wrap;
  logic        busy;
  logic [1:0]  grant_id;

  bram_write_arbiter #(
    .REQ_W    (2),
    .ADDR_W   (12),
    .RAM_WIDTH(16),
    .MAX_BURST(MB)
  ) dut (
    .clka       (clka),
    .rstb       (rstb),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .addra      (addra),
    .dina       (dina),
    .wea        (wea),
    .frame_done (frame_done),
    .region_wrap(region_wrap),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  always #5 clka = ~clka;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: reset values as they stand after the first (reset) edge.
  int         m_ptr [NUM] = '{default: 0};
  bit         m_burst = 0;
  int         m_gid = 0, m_cnt = 0, m_last = NUM - 1;
  logic       m_wea = 0;
  logic [11:0] m_addr = '0;
  logic [15:0] m_din = '0;
  logic [3:0] m_fd = '0, m_rw = '0;

  // Observed DUT activity for the directed checks.
  logic [11:0] wr_addr [$];
  logic [15:0] wr_data [$];
  logic [3:0]  wr_fd [$];
  logic [3:0]  wr_rw [$];
  logic [1:0]  glog [$];
  logic        busy_prev = 1'b0;

  always @(posedge clka) begin
    if (rstb) begin
      m_ptr = '{default: 0};
      m_burst = 0; m_gid = 0; m_cnt = 0; m_last = NUM - 1;
      m_wea = 0; m_addr = '0; m_din = '0; m_fd = '0; m_rw = '0;
    end else begin
      m_wea = 0; m_fd = '0; m_rw = '0;
      if (!m_burst) begin
        for (int k = 1; k <= NUM; k++) begin
          int c;
          c = (m_last + k) % NUM;
          if (!m_burst && req_valid[c]) begin
            m_burst = 1; m_gid = c; m_cnt = 0;
          end
        end
      end else begin
        int g;
        bit fin;
        g = m_gid;
        fin = 0;
        if (req_valid[g]) begin
          m_wea  = 1;
          m_addr = 12'(g * REGION + m_ptr[g]);
          m_din  = req_data[g*16 +: 16];
          m_cnt++;
          if (req_last[g]) begin
            m_ptr[g] = 0; m_fd[g] = 1'b1; fin = 1;
          end else if (m_ptr[g] == REGION - 1) begin
            m_ptr[g] = 0; m_rw[g] = 1'b1;
          end else begin
            m_ptr[g]++;
          end
          if (m_cnt == MB) fin = 1;
        end else begin
          fin = 1;
        end
        if (fin) begin
          m_burst = 0; m_last = g;
        end
      end
    end
    #2;
    chk("wea", 32'(wea), 32'(m_wea));
    chk("addra", 32'(addra), 32'(m_addr));
    chk("dina", 32'(dina), 32'(m_din));
    chk("frame_done", 32'(frame_done), 32'(m_fd));
    chk("region_wrap", 32'(region_wrap), 32'(m_rw));
    chk("busy", 32'(busy), 32'(m_burst));
    chk("grant_id", 32'(grant_id), 32'(m_gid));
    chk("req_ready", 32'(req_ready), (m_burst && !rstb) ? (32'd1 << m_gid) : 32'd0);
    if (wea === 1'b1) begin
      wr_addr.push_back(addra); wr_data.push_back(dina);
      wr_fd.push_back(frame_done); wr_rw.push_back(region_wrap);
    end
    if (busy === 1'b1 && busy_prev !== 1'b1) glog.push_back(grant_id);
    busy_prev = busy;
  end

  function automatic logic [31:0] wa(input int i);
    return (i < wr_addr.size()) ? 32'(wr_addr[i]) : 32'hDEAD;
  endfunction
  function automatic logic [31:0] wd(input int i);
    return (i < wr_data.size()) ? 32'(wr_data[i]) : 32'hDEAD;
  endfunction
  function automatic logic [31:0] gl(input int i);
    return (i < glog.size()) ? 32'(glog[i]) : 32'hDEAD;
  endfunction

  task automatic clear_logs();
    wr_addr.delete(); wr_data.delete(); wr_fd.delete(); wr_rw.delete(); glog.delete();
  endtask

  // Called at a negedge; returns at a negedge with reset released.
  task automatic do_reset();
    rstb = 1'b1; req_valid = '0; req_last = '0;
    repeat (2) @(negedge clka);
    rstb = 1'b0;
    clear_logs();
  endtask

  // Returns at the negedge just after the edge that accepted the beat.
  task automatic wait_ready(input int r);
    int t = 0;
    while (req_ready[r] !== 1'b1 && t < 50) begin
      @(negedge clka);
      t++;
    end
    if (t >= 50) chk("ready_timeout", 32'd0, 32'd1);
    @(negedge clka);
  endtask

  task automatic send(input int r, input int n, input bit lst, input logic [15:0] base);
    for (int b = 0; b < n; b++) begin
      req_valid[r] = 1'b1;
      req_data[r*16 +: 16] = base + 16'(b);
      req_last[r] = lst && (b == n - 1);
      wait_ready(r);
    end
    req_valid[r] = 1'b0;
    req_last[r] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clka);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_ready", 32'(req_ready), 32'd0);
    do_reset();

    // Single requester, 3-beat frame.
    send(2, 3, 1'b1, 16'hA1);
    repeat (2) @(negedge clka);
    chk("single_a0", wa(0), 32'h800);
    chk("single_a1", wa(1), 32'h801);
    chk("single_a2", wa(2), 32'h802);
    chk("single_d2", wd(2), 32'hA3);
    chk("single_fd", (wr_fd.size() > 2) ? 32'(wr_fd[2]) : 32'hDEAD, 32'h4);
    chk("single_busy", 32'(busy), 32'd0);
    clear_logs();
    send(2, 1, 1'b1, 16'hB0);
    repeat (2) @(negedge clka);
    chk("single_ptr0", wa(0), 32'h800);

    // Fairness with continuous valids and no last.
    do_reset();
    req_data = 64'h3000_2000_1000_0000;
    req_valid = 4'hF;
    repeat (24) @(negedge clka);
    req_valid = '0;
    repeat (2) @(negedge clka);
    for (int i = 0; i < 5; i++) chk("fair_grant", gl(i), 32'(i % 4));
    chk("fair_a3", wa(3), 32'h003);
    chk("fair_a4", wa(4), 32'h400);
    chk("fair_a8", wa(8), 32'h800);
    chk("fair_a12", wa(12), 32'hC00);
    chk("fair_a16", wa(16), 32'h004);

    // Region wrap on requester 1.
    do_reset();
    send(1, 1023, 1'b0, 16'h0000);
    clear_logs();
    send(1, 2, 1'b0, 16'h5555);
    repeat (2) @(negedge clka);
    chk("wrap_a0", wa(0), 32'h7FF);
    chk("wrap_d0", wd(0), 32'h5555);
    chk("wrap_rw0", (wr_rw.size() > 0) ? 32'(wr_rw[0]) : 32'hDEAD, 32'h2);
    chk("wrap_a1", wa(1), 32'h400);
    chk("wrap_rw1", (wr_rw.size() > 1) ? 32'(wr_rw[1]) : 32'hDEAD, 32'h0);

    // Valid drop releases the grant; waiting requester 3 goes next.
    do_reset();
    req_valid[3] = 1'b1;
    req_data[48 +: 16] = 16'hD3;
    send(0, 2, 1'b0, 16'h000A);
    @(negedge clka);
    req_valid[0] = 1'b1;
    repeat (6) @(negedge clka);
    req_valid = '0;
    repeat (2) @(negedge clka);
    chk("drop_g0", gl(0), 32'd0);
    chk("drop_g1", gl(1), 32'd3);
    chk("drop_a2", wa(2), 32'hC00);

    // Priority straight after reset.
    do_reset();
    req_data = 64'h00F3_0000_0000_00F0;
    req_valid = 4'b1001;
    req_last = 4'b1001;
    repeat (5) @(negedge clka);
    req_valid = '0;
    req_last = '0;
    repeat (2) @(negedge clka);
    chk("prio_g0", gl(0), 32'd0);
    chk("prio_g1", gl(1), 32'd3);
    chk("prio_a0", wa(0), 32'h000);
    chk("prio_a1", wa(1), 32'hC00);
    chk("prio_fd1", (wr_fd.size() > 1) ? 32'(wr_fd[1]) : 32'hDEAD, 32'h8);

    // Reset in the cycle of requester 1's third beat.
    do_reset();
    send(1, 2, 1'b0, 16'h0011);
    req_valid[1] = 1'b1;
    req_data[16 +: 16] = 16'h0013;
    rstb = 1'b1;
    @(negedge clka);
    chk("mid_nwrites", 32'(wr_addr.size()), 32'd2);
    chk("mid_wea", 32'(wea), 32'd0);
    chk("mid_addra", 32'(addra), 32'd0);
    chk("mid_dina", 32'(dina), 32'd0);
    chk("mid_ready", 32'(req_ready), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    rstb = 1'b0;
    clear_logs();
    send(1, 1, 1'b1, 16'h0077);
    repeat (2) @(negedge clka);
    chk("mid_after_a", wa(0), 32'h400);
    chk("mid_after_d", wd(0), 32'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
